// File: rtl/exec_class_wr_tracker_pkg.sv
// Shared CPU types for the write-register broadcast: the wr_reg_info bundle,
// class count, generic Tnew constants and the Tnew ageing helper.
package cpu_types;
  localparam int REG_ADDR_W     = 5;
  localparam int TNEW_W         = 3;
  localparam int EXEC_CLASS_NUM = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [TNEW_W-1:0]     Tnew;
  } wr_reg_info;

  localparam logic [TNEW_W-1:0] ALU_GEN = 3'd1;
  localparam logic [TNEW_W-1:0] MEM_GEN = 3'd3;

  // One pipeline step: Tnew counts down and sticks at zero.
  function automatic wr_reg_info age_entry(input wr_reg_info e);
    age_entry = e;
    if (e.Tnew != '0) begin
      age_entry.Tnew = e.Tnew - 1'b1;
    end
  endfunction
endpackage

// File: rtl/exec_class_wr_tracker_lane_shift.sv
// One lane of in-flight writes: an NSTAGE-deep shift of wr_reg_info with
// saturating Tnew decrement, stall hold and flush clear.
module wr_lane_shift
  import cpu_types::*;
#(
  parameter int NSTAGE = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  wr_reg_info              in_wd,
  output wr_reg_info [NSTAGE-1:0] stage_o
);
  wr_reg_info [NSTAGE-1:0] stage_q;
  wr_reg_info [NSTAGE-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      // An issue to r0 is stored as an all-zero (invalid) entry.
      stage_d[0] = (in_valid && (in_wd.addr != '0)) ? in_wd : '0;
      for (int s = 1; s < NSTAGE; s++) begin
        stage_d[s] = age_entry(stage_q[s-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;
endmodule

// File: rtl/exec_class_wr_tracker.sv
// Per-execution-class producer of the wr_reg_info wake-up broadcast: two lane
// trackers, the same-cycle way-0 bypass bundle and the pending-write mask.
module exec_class_wr_tracker
  import cpu_types::*;
#(
  parameter int NSTAGE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       issue_valid,
  input  wr_reg_info [1:0] issue_wd,
  input  logic             stall,
  input  logic             flush,
  output wr_reg_info [1:0] wd_o,
  output wr_reg_info       wd_way0_o,
  output logic [31:0]      pending_mask,
  output wr_reg_info [1:0] wb_o
);
  wr_reg_info [NSTAGE-1:0] lane_stage [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      wr_lane_shift #(.NSTAGE(NSTAGE)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .in_valid (issue_valid[gi]),
        .in_wd    (issue_wd[gi]),
        .stage_o  (lane_stage[gi])
      );
      assign wd_o[gi] = lane_stage[gi][0];
      assign wb_o[gi] = lane_stage[gi][NSTAGE-1];
    end
  endgenerate

  always_comb begin
    wd_way0_o = '0;
    if (issue_valid[0] && !stall && !flush) begin
      wd_way0_o = issue_wd[0];
    end
  end

  // WAW across lanes or stages needs no priority: the mask is a plain OR.
  always_comb begin
    pending_mask = '0;
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < NSTAGE; s++) begin
        if ((lane_stage[l][s].addr != '0) && (lane_stage[l][s].Tnew != '0)) begin
          pending_mask[lane_stage[l][s].addr] = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_class_wr_tracker.sv
// Bench for exec_class_wr_tracker: directed vector table, a hand sequence and
// randomized traffic checked against an age-based in-flight record model.
module tb_exec_class_wr_tracker;
  import cpu_types::*;

  localparam int NSTAGE = 3;

  logic             clk;
  logic             reset;
  logic [1:0]       issue_valid;
  wr_reg_info [1:0] issue_wd;
  logic             stall;
  logic             flush;
  wr_reg_info [1:0] wd_o;
  wr_reg_info       wd_way0_o;
  logic [31:0]      pending_mask;
  wr_reg_info [1:0] wb_o;

  int n_tests = 0;
  int n_fail  = 0;

  exec_class_wr_tracker #(.NSTAGE(NSTAGE)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_wd     (issue_wd),
    .stall        (stall),
    .flush        (flush),
    .wd_o         (wd_o),
    .wd_way0_o    (wd_way0_o),
    .pending_mask (pending_mask),
    .wb_o         (wb_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: each issued write is a record with its lane, issue Tnew and age
  // (edges survived). Its Tnew now is max(t0 - age, 0); it leaves at age NSTAGE.
  typedef struct {
    int lane;
    int addr;
    int t0;
    int age;
  } rec_t;
  rec_t inflight[$];

  function automatic int rec_tnew(rec_t r);
    return (r.t0 > r.age) ? (r.t0 - r.age) : 0;
  endfunction

  function automatic logic [7:0] m_entry(int lane, int age);
    logic [7:0] v;
    v = 8'h00;
    foreach (inflight[i]) begin
      if (inflight[i].lane == lane && inflight[i].age == age) begin
        v = {inflight[i].addr[4:0], 3'(rec_tnew(inflight[i]))};
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = 32'h0;
    foreach (inflight[i]) begin
      if (inflight[i].addr != 0 && rec_tnew(inflight[i]) > 0) begin
        m[inflight[i].addr] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic model_edge();
    rec_t kept[$];
    rec_t r;
    if (reset || flush) begin
      inflight.delete();
    end else if (!stall) begin
      foreach (inflight[i]) begin
        r = inflight[i];
        r.age++;
        if (r.age < NSTAGE) kept.push_back(r);
      end
      for (int l = 0; l < 2; l++) begin
        if (issue_valid[l] && issue_wd[l].addr != 5'd0) begin
          r.lane = l;
          r.addr = int'(issue_wd[l].addr);
          r.t0   = int'(issue_wd[l].Tnew);
          r.age  = 0;
          kept.push_back(r);
        end
      end
      inflight = kept;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wr_reg_info mk_wd(int addr, int tnew);
    wr_reg_info w;
    if (tnew > 7) $display("[TB] note: illegal issue Tnew %0d truncated to field width", tnew);
    w.addr = 5'(addr);
    w.Tnew = 3'(tnew);
    return w;
  endfunction

  // Drive one cycle: check the bypass before the edge, then all registered
  // outputs against the model after it.
  task automatic apply(input logic rst, input logic stl, input logic fl,
                       input logic [1:0] vld, input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] exp_way0;
    reset = rst; stall = stl; flush = fl; issue_valid = vld;
    issue_wd[0] = w0; issue_wd[1] = w1;
    #1;
    exp_way0 = (vld[0] && !stl && !fl) ? w0 : 8'h00;
    check("wd_way0", 32'(wd_way0_o), 32'(exp_way0));
    @(posedge clk);
    model_edge();
    #1;
    check("wd0_model",  32'(wd_o[0]), 32'(m_entry(0, 0)));
    check("wd1_model",  32'(wd_o[1]), 32'(m_entry(1, 0)));
    check("wb0_model",  32'(wb_o[0]), 32'(m_entry(0, NSTAGE-1)));
    check("wb1_model",  32'(wb_o[1]), 32'(m_entry(1, NSTAGE-1)));
    check("mask_model", pending_mask, m_mask());
  endtask

  typedef struct {
    logic       rst, stl, fl;
    logic [1:0] vld;
    logic [7:0] w0, w1;
    logic [7:0] e_wd0, e_wb0;
    logic [31:0] e_mask;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic stl, input logic fl, input logic [1:0] vld,
                     input logic [7:0] w0, input logic [7:0] w1,
                     input logic [7:0] e_wd0, input logic [7:0] e_wb0, input logic [31:0] e_mask);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.vld = vld; v.w0 = w0; v.w1 = w1;
    v.e_wd0 = e_wd0; v.e_wb0 = e_wb0; v.e_mask = e_mask;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; issue_valid = 2'b00; issue_wd = '0;

    //   rst  stl  fl   vld    w0            w1            e_wd0         e_wb0         e_mask
    // single issue countdown
    add(1'b0,1'b0,1'b0,2'b01,{5'd8,3'd2}, 8'h00,        {5'd8,3'd2}, 8'h00,        32'h100);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h100);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        {5'd8,3'd0}, 32'h0);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h0);
    // stall hold for two cycles, then resume decrement
    add(1'b0,1'b0,1'b0,2'b01,{5'd3,3'd3}, 8'h00,        {5'd3,3'd3}, 8'h00,        32'h8);
    add(1'b0,1'b1,1'b0,2'b00,8'h00,        8'h00,        {5'd3,3'd3}, 8'h00,        32'h8);
    add(1'b0,1'b1,1'b0,2'b00,8'h00,        8'h00,        {5'd3,3'd3}, 8'h00,        32'h8);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h8);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        {5'd3,3'd1}, 32'h8);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h0);
    // flush with simultaneous issue
    add(1'b0,1'b0,1'b0,2'b11,{5'd9,3'd2}, {5'd7,3'd3}, {5'd9,3'd2}, 8'h00,        32'h280);
    add(1'b0,1'b0,1'b1,2'b01,{5'd9,3'd2}, 8'h00,        8'h00,        8'h00,        32'h0);
    // reset with entries live
    add(1'b0,1'b0,1'b0,2'b01,{5'd5,3'd3}, 8'h00,        {5'd5,3'd3}, 8'h00,        32'h20);
    add(1'b1,1'b0,1'b0,2'b01,{5'd5,3'd3}, 8'h00,        8'h00,        8'h00,        32'h0);
    // dual issue WAW on r4
    add(1'b0,1'b0,1'b0,2'b11,{5'd4,3'd1}, {5'd4,3'd3}, {5'd4,3'd1}, 8'h00,        32'h10);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h10);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        {5'd4,3'd0}, 32'h10);
    add(1'b0,1'b0,1'b0,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h0);
    // addr 0 issue, bypass, bypass under stall, flush
    add(1'b0,1'b0,1'b0,2'b01,{5'd0,3'd3}, 8'h00,        8'h00,        8'h00,        32'h0);
    add(1'b0,1'b0,1'b0,2'b01,{5'd6,3'd1}, 8'h00,        {5'd6,3'd1}, 8'h00,        32'h40);
    add(1'b0,1'b1,1'b0,2'b01,{5'd6,3'd1}, 8'h00,        {5'd6,3'd1}, 8'h00,        32'h40);
    add(1'b0,1'b0,1'b1,2'b00,8'h00,        8'h00,        8'h00,        8'h00,        32'h0);

    // reset state
    apply(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    apply(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    check("reset_wd0",  32'(wd_o[0]), 32'h0);
    check("reset_wb1",  32'(wb_o[1]), 32'h0);
    check("reset_mask", pending_mask, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].vld, tbl[i].w0, tbl[i].w1);
      check($sformatf("vec%0d_wd0", i),  32'(wd_o[0]), 32'(tbl[i].e_wd0));
      check($sformatf("vec%0d_wb0", i),  32'(wb_o[0]), 32'(tbl[i].e_wb0));
      check($sformatf("vec%0d_mask", i), pending_mask, tbl[i].e_mask);
      $display("[TB] vec %0d: wd0=0x%0h wb0=0x%0h mask=0x%0h", i, wd_o[0], wb_o[0], pending_mask);
    end

    // Hand sequence: flush arriving during a stall still clears lane 1.
    apply(1'b0, 1'b0, 1'b0, 2'b10, 8'h00, mk_wd(10, 3));
    apply(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    check("stall_hold_wd1", 32'(wd_o[1]), 32'({5'd10, 3'd3}));
    check("stall_hold_mask", pending_mask, 32'h400);
    apply(1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
    check("flush_in_stall_wd1", 32'(wd_o[1]), 32'h0);
    check("flush_in_stall_mask", pending_mask, 32'h0);
    $display("[TB] hand seq: wd1=0x%0h mask=0x%0h", wd_o[1], pending_mask);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic rst, stl, fl;
      logic [1:0] vld;
      wr_reg_info w0, w1;
      rst = ($urandom_range(0, 49) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      stl = ($urandom_range(0, 5) == 0);
      vld = 2'($urandom_range(0, 3));
      w0  = mk_wd(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  $urandom_range(0, 7));
      w1  = mk_wd(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  $urandom_range(0, 7));
      apply(rst, stl, fl, vld, w0, w1);
      $display("[TB] rnd %0d: rst=%0b stl=%0b fl=%0b vld=%b w0=0x%0h w1=0x%0h mask=0x%0h",
               i, rst, stl, fl, vld, w0, w1, pending_mask);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
